// File: rtl/uart_tx_frame.sv
// Frame-level UART transmitter: turns the baud divider's clock into bit ticks and
// serialises start, LSB-first data, optional parity and stop bits onto tx.
module uart_tx_frame #(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_clk,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP   = 3'd5
    } state_t;

    localparam logic [2:0] LAST_IDX  = 3'(DATA_BITS - 1);
    localparam logic       LAST_STOP = (STOP_BITS == 2) ? 1'b1 : 1'b0;

    function automatic logic parity_f(input logic [DATA_BITS-1:0] d);
        return (PARITY == 2) ? ~(^d) : (^d);
    endfunction

    state_t                 state_q, state_d;
    logic [2:0]             sync_q;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic [2:0]             idx_q, idx_d;
    logic                   stop_q, stop_d;
    logic                   tx_q, tx_d;
    logic                   ready_q, ready_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   tick_s;

    // baud_clk is asynchronous: sync_q[0..2] are b1, b2, b3; a tick marks each rising edge
    assign tick_s = sync_q[1] & ~sync_q[2];

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            sync_q  <= 3'b000;
            data_q  <= '0;
            idx_q   <= 3'd0;
            stop_q  <= 1'b0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[1:0], baud_clk};
            data_q  <= data_d;
            idx_q   <= idx_d;
            stop_q  <= stop_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and next-output logic; everything advances only on a tick
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        idx_d   = idx_q;
        stop_d  = stop_q;
        tx_d    = tx_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tx_d    = 1'b1;
                ready_d = 1'b1;
                busy_d  = 1'b0;
                if (tx_valid && ready_q) begin
                    data_d  = tx_data;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (tick_s) begin
                    tx_d    = 1'b0;
                    state_d = ST_START;
                end else begin
                    tx_d    = 1'b1;
                end
            end
            ST_START: begin
                if (tick_s) begin
                    idx_d   = 3'd0;
                    tx_d    = data_q[0];
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (tick_s) begin
                    if (idx_q < LAST_IDX) begin
                        idx_d = idx_q + 3'd1;
                        tx_d  = data_q[idx_q + 3'd1];
                    end else if (PARITY != 0) begin
                        tx_d    = parity_f(data_q);
                        state_d = ST_PARITY;
                    end else begin
                        tx_d    = 1'b1;
                        stop_d  = 1'b0;
                        state_d = ST_STOP;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (tick_s) begin
                    tx_d    = 1'b1;
                    stop_d  = 1'b0;
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_STOP: begin
                tx_d = 1'b1;
                if (tick_s) begin
                    if (stop_q == LAST_STOP) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        ready_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        stop_d = stop_q + 1'b1;
                    end
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                tx_d    = 1'b1;
                ready_d = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign tx       = tx_q;
    assign tx_ready = ready_q;
    assign tx_busy  = busy_q;
    assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: four configurations (8N1, 8E1, 8O1, 7N2) on a
// shared 16-clk baud clock; a receiver-style monitor decodes frames and checks timing.
module tb_uart_tx_frame;

    logic       clk = 1'b0;
    logic       rst;
    logic       baud_clk;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       vld[4];
    logic       tx_w[4];
    logic       rdy_w[4];
    logic       busy_w[4];
    logic       done_w[4];
    int         cur;
    int         checks = 0;
    int         failures = 0;
    bit         mon_en;
    int         done_cnt[4] = '{default: 0};
    logic       tb_b1 = 1'b0, tb_b2 = 1'b0, tb_b3 = 1'b0;
    logic       tb_tick;

    typedef struct {
        logic [15:0] bits;
        int          n;
    } frame_t;
    frame_t exp_q[$];

    always #5 clk = ~clk;

    initial begin
        baud_clk = 1'b0;
        #3;
        forever #80 baud_clk = ~baud_clk;
    end

    // Reference tick: same three-flop edge detector the transmitter is defined with
    always @(posedge clk) begin
        tb_b1 <= baud_clk;
        tb_b2 <= tb_b1;
        tb_b3 <= tb_b2;
    end
    assign tb_tick = tb_b2 & ~tb_b3;

    always_comb begin
        for (int i = 0; i < 4; i++) vld[i] = tx_valid && (cur == i);
    end

    // Count tx_done pulses per instance
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) if (done_w[i]) done_cnt[i] <= done_cnt[i] + 1;
    end

    uart_tx_frame #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .rst(rst), .baud_clk(baud_clk), .tx_data(tx_data), .tx_valid(vld[0]),
        .tx_ready(rdy_w[0]), .tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0]));
    uart_tx_frame #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .rst(rst), .baud_clk(baud_clk), .tx_data(tx_data), .tx_valid(vld[1]),
        .tx_ready(rdy_w[1]), .tx(tx_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1]));
    uart_tx_frame #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8o1 (
        .clk(clk), .rst(rst), .baud_clk(baud_clk), .tx_data(tx_data), .tx_valid(vld[2]),
        .tx_ready(rdy_w[2]), .tx(tx_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2]));
    uart_tx_frame #(.DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_7n2 (
        .clk(clk), .rst(rst), .baud_clk(baud_clk), .tx_data(tx_data[6:0]), .tx_valid(vld[3]),
        .tx_ready(rdy_w[3]), .tx(tx_w[3]), .tx_busy(busy_w[3]), .tx_done(done_w[3]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (inst %0d, t=%0t)", name, act, exp, cur, $time);
        end
    endtask

    // Monitor: decode each frame by sampling mid-bit, check done/ready timing
    initial begin : monitor
        logic        prev;
        frame_t      f;
        logic [15:0] got;
        int          n;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (mon_en && rst && prev && !tx_w[cur]) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_frame: got start bit expected none (inst %0d)", cur);
                    f.bits = 16'h0000;
                    f.n    = 10;
                end else begin
                    f = exp_q.pop_front();
                end
                n   = f.n;
                got = 16'h0000;
                for (int k = 0; k <= n * 16; k++) begin
                    if (k > 0) @(negedge clk);
                    if ((k % 16) == 8 && (k / 16) < n) got[k / 16] = tx_w[cur];
                    if (k == n * 16 - 1) begin
                        chk("done_before_end", done_w[cur], 32'd0);
                        chk("ready_during_frame", rdy_w[cur], 32'd0);
                    end
                end
                chk("frame_bits", got, f.bits);
                chk("done_pulse_at_end", done_w[cur], 32'd1);
                chk("ready_at_done", rdy_w[cur], 32'd1);
            end
            prev = tx_w[cur];
        end
    end

    task automatic wait_accept(input int idx);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (!rdy_w[idx]) ok = 1'b1;
        end
        chk("accept", ok, 32'd1);
    endtask

    task automatic wait_idle(input int idx);
        int lat;
        lat = 0;
        while (busy_w[idx] && lat < 400) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("frame_ends", busy_w[idx], 32'd0);
        repeat (4) @(negedge clk);
    endtask

    task automatic send(input int idx, input logic [7:0] d, input logic [15:0] bits,
                        input int n, input bit align);
        frame_t f;
        int     lat;
        f.bits = bits;
        f.n    = n;
        exp_q.push_back(f);
        cur = idx;
        @(negedge clk);
        if (align) begin
            lat = 0;
            while (!tb_tick && lat < 40) begin
                @(negedge clk);
                lat++;
            end
        end
        tx_data  = d;
        tx_valid = 1'b1;
        wait_accept(idx);
        tx_valid = 1'b0;
        lat = 0;
        while (tx_w[idx] && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (align) chk("start_after_tick_handshake", lat, 32'd16);
        else       chk("start_latency", (lat >= 1 && lat <= 16), 32'd1);
        wait_idle(idx);
    endtask

    initial begin : stim
        int  d0;
        int  lat;
        bit  ok;
        frame_t f;
        rst      = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        cur      = 0;
        mon_en   = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            cur = i;
            chk("reset_tx", tx_w[i], 32'd1);
            chk("reset_ready", rdy_w[i], 32'd1);
            chk("reset_busy", busy_w[i], 32'd0);
            chk("reset_done", done_w[i], 32'd0);
        end
        rst = 1'b1;
        repeat (40) @(negedge clk);
        mon_en = 1'b1;

        send(0, 8'h55, 16'b000000_1_01010101_0, 10, 1'b0);
        send(1, 8'hA3, 16'b00000_1_0_10100011_0, 11, 1'b0);
        send(2, 8'hA3, 16'b00000_1_1_10100011_0, 11, 1'b0);
        send(3, 8'h7F, 16'b000000_11_1111111_0, 10, 1'b0);
        send(0, 8'h3C, 16'b000000_1_00111100_0, 10, 1'b1);

        // Back-to-back with tx_valid held; mid-frame data changes must not leak
        cur = 0;
        d0  = done_cnt[0];
        f.n = 10;
        f.bits = 16'b000000_1_00010001_0;
        exp_q.push_back(f);
        f.bits = 16'b000000_1_00100010_0;
        exp_q.push_back(f);
        @(negedge clk);
        tx_data  = 8'h11;
        tx_valid = 1'b1;
        wait_accept(0);
        repeat (40) @(negedge clk);
        tx_data = 8'h99;
        repeat (40) @(negedge clk);
        tx_data = 8'h22;
        lat = 0;
        while (!rdy_w[0] && lat < 400) begin
            @(posedge clk);
            #1;
            lat++;
        end
        ok = 1'b0;
        for (int i = 0; i < 3 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (!rdy_w[0]) ok = 1'b1;
        end
        chk("b2b_second_accept", ok, 32'd1);
        tx_valid = 1'b0;
        wait_idle(0);
        chk("b2b_two_done_pulses", done_cnt[0] - d0, 32'd2);

        // Reset during data bit 3 (0xF0 has d3=0, so tx is low when reset hits)
        mon_en = 1'b0;
        @(negedge clk);
        tx_data  = 8'hF0;
        tx_valid = 1'b1;
        wait_accept(0);
        tx_valid = 1'b0;
        lat = 0;
        while (tx_w[0] && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        repeat (16 * 4 + 8) @(posedge clk);
        @(negedge clk);
        chk("busy_mid_frame", busy_w[0], 32'd1);
        chk("tx_data_bit3", tx_w[0], 32'd0);
        rst = 1'b0;
        #1;
        chk("abort_tx_high", tx_w[0], 32'd1);
        chk("abort_ready", rdy_w[0], 32'd1);
        chk("abort_busy", busy_w[0], 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        mon_en = 1'b1;
        send(0, 8'h0F, 16'b000000_1_00001111_0, 10, 1'b0);

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- Serial UART transmitter; direct downstream consumer of the UART baud divider output (the divider's toggling clk_div_addr drives this block's baud_clk input).
- Runs entirely on the system clock. baud_clk is treated as a data signal: it is synchronised, and its rising edges become one-cycle bit ticks.
- Accepts parallel bytes through a valid/ready handshake. Emits start, data (LSB first), optional parity and stop bits on tx.

Parameters:
- DATA_BITS, 8, payload width per frame; legal values 5..8.
- PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  asynchronous, active-low reset.
- baud_clk  input  1  divided baud clock from the baud divider; asynchronous to this block's logic.
- tx_data  input  DATA_BITS  byte to send; sampled only on handshake.
- tx_valid  input  1  producer has data.
- tx_ready  output  1  block can accept a frame.
- tx  output  1  serial line; idle high.
- tx_busy  output  1  frame in progress.
- tx_done  output  1  one-cycle pulse at end of the last stop bit.

Behaviour:
- Reset (rst=0, asynchronous): tx=1, tx_ready=1, tx_busy=0, tx_done=0, state=IDLE, shift register cleared, sync flops cleared. Any frame in flight is abandoned; tx returns high immediately.
- Tick generation: three flops b1<=baud_clk, b2<=b1, b3<=b2; tick = b2 & ~b3. tick goes high exactly one cycle per baud_clk rising edge, 2 clk cycles after b1 captures the high level. baud_clk falling edges are ignored. One bit period is one baud_clk period, rising edge to rising edge.
- Handshake: accept when tx_valid & tx_ready at a posedge. On that edge:
  - latch tx_data;
  - tx_ready falls and tx_busy rises from the next cycle;
  - state goes to WAIT.
- tx_data and tx_valid are don't-care while tx_ready=0. No second frame is queued.
- States and transitions:
  - IDLE: tx=1, tx_ready=1. Handshake -> WAIT.
  - WAIT: tx=1. On tick -> START with tx=0. A tick in the same cycle as the handshake does NOT start the frame; the start bit begins on the next tick.
  - START: on tick -> DATA, bit index=0, tx=data[0].
  - DATA: on tick, if index < DATA_BITS-1: index+1, tx=next bit. Otherwise go to PARITY if PARITY != 0, else STOP, tx=1.
  - PARITY: tx = XOR of all data bits (even) or its complement (odd). On tick -> STOP, tx=1.
  - STOP: tx=1. Hold for STOP_BITS ticks. On the final tick: tx_done=1 for that single cycle, tx_busy=0, tx_ready=1, state=IDLE.
- Back-to-back: when tx_valid is held high, the next handshake occurs the cycle after return to IDLE. Lines remains high until the following tick starts the next start bit, so the minimum inter-frame gap is 0 extra bit periods beyond the stop bits plus the WAIT alignment.
- tx is a registered output and never glitches; it only changes on tick cycles or on reset.
- Frame length in ticks from START to done: 1 + DATA_BITS + (PARITY!=0) + STOP_BITS.
- baud_clk stopped mid-frame: the state is held indefinitely; no timeout.

Test Plan:
- 8N1, tx_data=0x55, baud_clk period 16 clk: tx per bit period = 0,1,0,1,0,1,0,1,0,1, then idle 1. tx_done pulses once, 10 ticks after the start bit.
- PARITY=1, tx_data=0xA3: data bits 1,1,0,0,0,1,0,1, parity bit 0, stop 1. With PARITY=2 and the same data, parity bit=1.
- STOP_BITS=2, DATA_BITS=7, tx_data=0x7F: 1 start + 7 ones + 2 stop high. tx_done arrives 10 ticks after start; tx_ready stays 0 until then.
- tx_valid held high with 0x11 then 0x22: two complete frames in order. tx_data changed mid-frame is not transmitted. Exactly two tx_done pulses.
- Handshake in the same cycle as tick: the start bit appears on the following tick, not the current one (tx stays 1 for one full bit period).
- rst asserted low during data bit 3: tx=1, tx_ready=1, tx_busy=0 immediately. After release, a new frame of 0x0F transmits correctly.
